// File: rtl/wb_tlc_req_fifo.sv
// rtl/wb_tlc_req_fifo.sv - Rx TLP request packet FIFO with show-ahead output register
// Build option: define WB_TLC_REQ_FIFO_SF_EN for store-and-forward mode; default is cut-through.
module wb_tlc_req_fifo #(
   parameter int c_DATA_WIDTH = 64,
   parameter int c_ADDR_WIDTH = 9
) (
   input  logic                    clk_125,
   input  logic                    rst,
   input  logic [c_DATA_WIDTH-1:0] fifo_dout,
   input  logic                    fifo_sop,
   input  logic                    fifo_eop,
   input  logic                    fifo_dwen,
   input  logic                    fifo_wrn,
   input  logic [6:0]              fifo_bar,
   input  logic                    fifo_wen,
   output logic [c_DATA_WIDTH-1:0] tlp_dout,
   output logic                    tlp_sop,
   output logic                    tlp_eop,
   output logic                    tlp_dwen,
   output logic                    tlp_wrn,
   output logic [6:0]              tlp_bar,
   output logic                    tlp_valid,
   input  logic                    tlp_ready,
   output logic [c_ADDR_WIDTH:0]   pkt_cnt,
   output logic                    full,
   output logic                    ovf_err
);

   localparam int                  c_WORD_WIDTH = c_DATA_WIDTH + 11;
   localparam logic [c_ADDR_WIDTH:0] c_DEPTH   = {1'b1, {c_ADDR_WIDTH{1'b0}}};
   localparam logic [c_ADDR_WIDTH:0] c_PTR_ONE = {{c_ADDR_WIDTH{1'b0}}, 1'b1};

   // Word RAM; pointers carry one extra wrap bit so occupancy is unambiguous at full.
   logic [c_WORD_WIDTH-1:0] mem [0:(1 << c_ADDR_WIDTH)-1];
   logic [c_ADDR_WIDTH:0]   wr_ptr;
   logic [c_ADDR_WIDTH:0]   rd_ptr;
   logic [c_ADDR_WIDTH:0]   occupancy;
   logic [c_WORD_WIDTH-1:0] wr_word;
   logic [c_WORD_WIDTH-1:0] rd_word;
   logic                    wr_acc;
   logic                    wr_ovf;
   logic                    avail;
   logic                    rd_load;
   logic                    rd_take;
   logic                    pkt_inc;
   logic                    pkt_dec;

   assign occupancy = wr_ptr - rd_ptr;
   assign full      = (occupancy == c_DEPTH);
   assign wr_ovf    = fifo_wen & full;
   assign wr_word   = {fifo_bar, fifo_wrn, fifo_dwen, fifo_eop, fifo_sop, fifo_dout};
   assign rd_word   = mem[rd_ptr[c_ADDR_WIDTH-1:0]];
   assign rd_take   = tlp_valid & tlp_ready;
   assign rd_load   = avail & (~tlp_valid | tlp_ready);
   assign pkt_inc   = wr_acc & fifo_eop;
   assign pkt_dec   = rd_take & tlp_eop;

`ifdef WB_TLC_REQ_FIFO_SF_EN
   // Words up to wr_cmt belong to packets whose eop has landed; only those are readable.
   logic [c_ADDR_WIDTH:0] wr_cmt;
   logic                  dropping;

   assign wr_acc = fifo_wen & ~full & ~dropping;
   assign avail  = (wr_cmt != rd_ptr);

   // Write pointer, commit point, and discard of an overflowed packet through its eop.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         wr_cmt   <= '0;
         dropping <= 1'b0;
      end else if (wr_ovf) begin
         wr_ptr   <= wr_cmt;
         dropping <= ~fifo_eop;
      end else if (wr_acc) begin
         wr_ptr <= wr_ptr + c_PTR_ONE;
         if (fifo_eop)
            wr_cmt <= wr_ptr + c_PTR_ONE;
      end else if (fifo_wen & dropping & fifo_eop) begin
         dropping <= 1'b0;
      end
   end
`else
   assign wr_acc = fifo_wen & ~full;
   assign avail  = (wr_ptr != rd_ptr);

   // Write pointer; any accepted word becomes readable on the next edge.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst)
         wr_ptr <= '0;
      else if (wr_acc)
         wr_ptr <= wr_ptr + c_PTR_ONE;
   end
`endif

   // RAM write port; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk_125) begin
      if (wr_acc)
         mem[wr_ptr[c_ADDR_WIDTH-1:0]] <= wr_word;
   end

   // Show-ahead output register: refill when empty or on the edge the head is taken.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         tlp_valid <= 1'b0;
         tlp_dout  <= '0;
         tlp_sop   <= 1'b0;
         tlp_eop   <= 1'b0;
         tlp_dwen  <= 1'b0;
         tlp_wrn   <= 1'b0;
         tlp_bar   <= '0;
      end else if (rd_load) begin
         {tlp_bar, tlp_wrn, tlp_dwen, tlp_eop, tlp_sop, tlp_dout} <= rd_word;
         tlp_valid <= 1'b1;
         rd_ptr    <= rd_ptr + c_PTR_ONE;
      end else if (rd_take) begin
         tlp_valid <= 1'b0;
      end
   end

   // Complete-packet count: eop accepted into the RAM minus eop handed to the consumer.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst)
         pkt_cnt <= '0;
      else if (pkt_inc & ~pkt_dec)
         pkt_cnt <= pkt_cnt + c_PTR_ONE;
      else if (pkt_dec & ~pkt_inc)
         pkt_cnt <= pkt_cnt - c_PTR_ONE;
   end

   // Sticky overflow flag; the decoder cannot be stalled, so any write at full is an error.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst)
         ovf_err <= 1'b0;
      else if (wr_ovf)
         ovf_err <= 1'b1;
   end

endmodule

// File: tb/tb_wb_tlc_req_fifo.sv
// tb/tb_wb_tlc_req_fifo.sv - directed vector bench for wb_tlc_req_fifo
module tb_wb_tlc_req_fifo;

   localparam int DW = 64;
   localparam int AW = 9;
   typedef logic [DW+10:0] word_t;

   typedef struct {
      logic          wen;
      word_t         w;
      logic          rdy;
      logic          ex_valid;
      word_t         ex_word;
      logic [AW:0]   ex_pkt;
   } vec_t;

   logic          clk_125 = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_sop = 1'b0;
   logic          fifo_eop = 1'b0;
   logic          fifo_dwen = 1'b0;
   logic          fifo_wrn = 1'b0;
   logic [6:0]    fifo_bar = '0;
   logic          fifo_wen = 1'b0;
   logic [DW-1:0] tlp_dout;
   logic          tlp_sop;
   logic          tlp_eop;
   logic          tlp_dwen;
   logic          tlp_wrn;
   logic [6:0]    tlp_bar;
   logic          tlp_valid;
   logic          tlp_ready = 1'b0;
   logic [AW:0]   pkt_cnt;
   logic          full;
   logic          ovf_err;

   always #4 clk_125 = ~clk_125;

   wb_tlc_req_fifo #(.c_DATA_WIDTH(DW), .c_ADDR_WIDTH(AW)) dut (
      .clk_125   (clk_125),
      .rst       (rst),
      .fifo_dout (fifo_dout),
      .fifo_sop  (fifo_sop),
      .fifo_eop  (fifo_eop),
      .fifo_dwen (fifo_dwen),
      .fifo_wrn  (fifo_wrn),
      .fifo_bar  (fifo_bar),
      .fifo_wen  (fifo_wen),
      .tlp_dout  (tlp_dout),
      .tlp_sop   (tlp_sop),
      .tlp_eop   (tlp_eop),
      .tlp_dwen  (tlp_dwen),
      .tlp_wrn   (tlp_wrn),
      .tlp_bar   (tlp_bar),
      .tlp_valid (tlp_valid),
      .tlp_ready (tlp_ready),
      .pkt_cnt   (pkt_cnt),
      .full      (full),
      .ovf_err   (ovf_err)
   );

   word_t tlp_word;
   assign tlp_word = {tlp_bar, tlp_wrn, tlp_dwen, tlp_eop, tlp_sop, tlp_dout};

   int    n_vec = 0;
   int    n_err = 0;
   word_t exp_q[$];
   vec_t  tv[7];

   function automatic word_t mk(input logic sop, input logic eop, input logic dwen, input logic wrn,
                                input logic [6:0] bar, input logic [DW-1:0] d);
      return {bar, wrn, dwen, eop, sop, d};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive write/ready, score any handshake, and check hold on a stall.
   task automatic cycle(input logic wen, input word_t w, input logic rdy);
      word_t held;
      logic  stall;
      {fifo_bar, fifo_wrn, fifo_dwen, fifo_eop, fifo_sop, fifo_dout} = w;
      fifo_wen  = wen;
      tlp_ready = rdy;
      held  = tlp_word;
      stall = tlp_valid & ~rdy;
      if (tlp_valid & rdy) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_word: got %0h expected no word", tlp_word);
         end else begin
            chk("hs_word", 128'(tlp_word), 128'(exp_q.pop_front()));
         end
      end
      @(posedge clk_125);
      #1;
      if (stall) begin
         chk("stall_hold", 128'(tlp_word), 128'(held));
         chk("stall_valid", 128'(tlp_valid), 128'(1));
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle(1'b0, '0, 1'b1);
         n++;
      end
      chk("drain_left", 128'(exp_q.size()), 128'(0));
      cycle(1'b0, '0, 1'b1);
      chk("drain_valid", 128'(tlp_valid), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      word_t a, b, c, z, w;
      word_t lw[4];
      logic  exp_v;
      int    cc;

      a = mk(1'b1, 1'b0, 1'b0, 1'b1, 7'h01, 64'h1111_0000_0000_0001);
      b = mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h01, 64'h2222_0000_0000_0002);
      c = mk(1'b0, 1'b1, 1'b1, 1'b1, 7'h01, 64'h3333_0000_0000_0003);
      z = '0;
`ifdef WB_TLC_REQ_FIFO_SF_EN
      tv[0] = '{1'b1, a, 1'b1, 1'b0, z, 10'd0};
      tv[1] = '{1'b1, b, 1'b1, 1'b0, z, 10'd0};
      tv[2] = '{1'b1, c, 1'b1, 1'b0, z, 10'd1};
      tv[3] = '{1'b0, z, 1'b1, 1'b1, a, 10'd1};
      tv[4] = '{1'b0, z, 1'b1, 1'b1, b, 10'd1};
      tv[5] = '{1'b0, z, 1'b1, 1'b1, c, 10'd1};
      tv[6] = '{1'b0, z, 1'b1, 1'b0, c, 10'd0};
`else
      tv[0] = '{1'b1, a, 1'b1, 1'b0, z, 10'd0};
      tv[1] = '{1'b1, b, 1'b1, 1'b1, a, 10'd0};
      tv[2] = '{1'b1, c, 1'b1, 1'b1, b, 10'd1};
      tv[3] = '{1'b0, z, 1'b1, 1'b1, c, 10'd1};
      tv[4] = '{1'b0, z, 1'b1, 1'b0, c, 10'd0};
      tv[5] = '{1'b0, z, 1'b1, 1'b0, c, 10'd0};
      tv[6] = '{1'b0, z, 1'b1, 1'b0, c, 10'd0};
`endif

      // Reset state
      repeat (3) @(posedge clk_125);
      #1;
      chk("rst_valid", 128'(tlp_valid), 128'(0));
      chk("rst_word", 128'(tlp_word), 128'(0));
      chk("rst_pkt", 128'(pkt_cnt), 128'(0));
      chk("rst_full", 128'(full), 128'(0));
      chk("rst_ovf", 128'(ovf_err), 128'(0));
      @(negedge clk_125);
      rst = 1'b0;
      @(posedge clk_125);
      #1;

      // 3-word MWr with tlp_ready=1, cycle-exact vectors
      for (int i = 0; i < 7; i++) begin
         {fifo_bar, fifo_wrn, fifo_dwen, fifo_eop, fifo_sop, fifo_dout} = tv[i].w;
         fifo_wen  = tv[i].wen;
         tlp_ready = tv[i].rdy;
         @(posedge clk_125);
         #1;
         chk($sformatf("t1_valid[%0d]", i), 128'(tlp_valid), 128'(tv[i].ex_valid));
         chk($sformatf("t1_word[%0d]", i), 128'(tlp_word), 128'(tv[i].ex_word));
         chk($sformatf("t1_pkt[%0d]", i), 128'(pkt_cnt), 128'(tv[i].ex_pkt));
      end

      // Latency of the first word of a 4-word packet, consumer stalled
      for (int i = 0; i < 4; i++) begin
         lw[i] = mk(i == 0, i == 3, 1'b0, 1'b0, 7'h10, 64'h4444_0000_0000_0000 + 64'(i));
         exp_q.push_back(lw[i]);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, lw[i], 1'b0);
`ifdef WB_TLC_REQ_FIFO_SF_EN
         exp_v = 1'b0;
`else
         exp_v = (i > 0);
`endif
         chk($sformatf("t2_valid[%0d]", i), 128'(tlp_valid), 128'(exp_v));
      end
      cycle(1'b0, '0, 1'b0);
      chk("t2_valid_post", 128'(tlp_valid), 128'(1));
      chk("t2_first", 128'(tlp_word), 128'(lw[0]));
      drain(20);

      // Fill to full, overflow, and the mode-specific fate of the faulting packet
      for (int i = 0; i < 4; i++) begin
         w = mk(i == 0, i == 3, 1'b0, 1'b1, 7'h02, 64'hA000 + 64'(i));
         exp_q.push_back(w);
         cycle(1'b1, w, 1'b0);
      end
      for (int i = 0; i < 509; i++) begin
         w = mk(i == 0, 1'b0, 1'b0, 1'b1, 7'h04, 64'hB000 + 64'(i));
`ifndef WB_TLC_REQ_FIFO_SF_EN
         exp_q.push_back(w);
`endif
         cycle(1'b1, w, 1'b0);
      end
      chk("t3_full", 128'(full), 128'(1));
      chk("t3_ovf_before", 128'(ovf_err), 128'(0));
      cycle(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h04, 64'hBEEF), 1'b0);
      chk("t3_ovf", 128'(ovf_err), 128'(1));
`ifdef WB_TLC_REQ_FIFO_SF_EN
      chk("t3_full_after", 128'(full), 128'(0));
`else
      chk("t3_full_after", 128'(full), 128'(1));
`endif
      cycle(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h04, 64'hB1FD), 1'b0);
      cycle(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 7'h04, 64'hB1FE), 1'b0);
      for (int i = 0; i < 2; i++) begin
         w = mk(i == 0, i == 1, 1'b0, 1'b0, 7'h08, 64'hC000 + 64'(i));
`ifdef WB_TLC_REQ_FIFO_SF_EN
         exp_q.push_back(w);
`endif
         cycle(1'b1, w, 1'b0);
      end
`ifdef WB_TLC_REQ_FIFO_SF_EN
      chk("t3_pkt", 128'(pkt_cnt), 128'(2));
`else
      chk("t3_pkt", 128'(pkt_cnt), 128'(1));
`endif
      chk("t3_ovf_sticky", 128'(ovf_err), 128'(1));
      drain(700);
      chk("t3_pkt_end", 128'(pkt_cnt), 128'(0));

      // Simultaneous eop write and eop read with two packets stored
      for (int i = 0; i < 6; i++) begin
         w = mk(i % 2 == 0, i % 2 == 1, 1'b0, 1'b1, 7'h20, 64'hE000 + 64'(i));
         exp_q.push_back(w);
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, exp_q[i], 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      chk("t4_pkt_two", 128'(pkt_cnt), 128'(2));
      cycle(1'b1, exp_q[4], 1'b1);
      chk("t4_pkt_mid", 128'(pkt_cnt), 128'(2));
      cycle(1'b1, exp_q[4], 1'b1);
      chk("t4_pkt_same", 128'(pkt_cnt), 128'(2));
      drain(20);

      // Continuous stream well past the pointer wrap
      for (int k = 0; k < 540; k++) begin
         w = mk(k % 3 == 0, k % 3 == 2, k[0], 1'b1, 7'h40, 64'hD000_0000 + 64'(k));
         exp_q.push_back(w);
         cycle(1'b1, w, 1'b1);
      end
      drain(50);
      chk("t4_pkt_end", 128'(pkt_cnt), 128'(0));
      chk("t4_full_end", 128'(full), 128'(0));

      // Two-packet burst with tlp_ready toggling 1010
      cc = 0;
      for (int i = 0; i < 5; i++) begin
         w = mk(i == 0 || i == 3, i == 2 || i == 4, 1'b0, 1'b0, 7'h11, 64'hF000 + 64'(i));
         exp_q.push_back(w);
         cycle(1'b1, w, cc % 2 == 0);
         cc++;
      end
      while (exp_q.size() != 0 && cc < 40) begin
         cycle(1'b0, '0, cc % 2 == 0);
         cc++;
      end
      chk("t5_left", 128'(exp_q.size()), 128'(0));
      chk("t5_pkt", 128'(pkt_cnt), 128'(0));

      // Reset in the middle of a packet
      chk("t6_ovf_sticky", 128'(ovf_err), 128'(1));
      cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 7'h03, 64'h6000), 1'b0);
      cycle(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 7'h03, 64'h6001), 1'b0);
      cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 7'h03, 64'h6002), 1'b0);
      cycle(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h03, 64'h6003), 1'b0);
      chk("t6_pkt_pre", 128'(pkt_cnt), 128'(1));
      fifo_wen = 1'b0;
      rst = 1'b1;
      @(posedge clk_125);
      #1;
      chk("t6_valid", 128'(tlp_valid), 128'(0));
      chk("t6_pkt", 128'(pkt_cnt), 128'(0));
      chk("t6_full", 128'(full), 128'(0));
      chk("t6_ovf", 128'(ovf_err), 128'(0));
      exp_q.delete();
      @(negedge clk_125);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w = mk(i == 0, i == 1, 1'b1, 1'b0, 7'h05, 64'h7000 + 64'(i));
         exp_q.push_back(w);
         cycle(1'b1, w, 1'b1);
      end
      drain(20);
      chk("t6_pkt_end", 128'(pkt_cnt), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
